fwd_unit_b: RTL
===============

// Module: fwd_unit_b
// PURPOSE
//  Forwarding and hazard unit for ALU operand B. Feeds mx_b: drives its forward and in_mxrb inputs.
//  Holds a 3-slot tag pipeline (EX, MEM, WB) of in-flight destination registers.
//  Compares the ID-stage rb address against those slots and registers a forward select for the EX stage.
//  Captures retiring WB data when needed and stalls ID for one cycle on a load-use hazard.
// PARAMETERS
//  DATA_W  32  operand/result width
//  REG_AW  5   register address width; address 0 is hard-wired zero and is never forwarded
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       asynchronous active-low reset
//  hold         in   1       global pipeline freeze; all internal state keeps its value
//  id_valid     in   1       ID stage holds a real instruction
//  id_rb_addr   in   REG_AW  rb source register of the ID instruction
//  id_use_rb    in   1       ID instruction reads rb from the register bank (S_MXSE=0)
//  id_wr_en     in   1       ID instruction writes a destination register
//  id_rd_addr   in   REG_AW  destination register of the ID instruction
//  id_is_load   in   1       ID instruction is a load
//  mem_result   in   DATA_W  result of the instruction currently in MEM
//  wb_result    in   DATA_W  result/load data of the instruction currently in WB
//  stall        out  1       load-use hazard; ID/IF must hold, EX receives a bubble
//  forward      out  1       to mx_b.forward
//  out_mxrb     out  DATA_W  to mx_b.in_mxrb
// BEHAVIOUR
//  Slot state: EX, MEM and WB slots, each holding {vld, wr, rd[REG_AW-1:0], ld}.
//  Reset: all slots vld=0, fwd_sel=NONE, ret_data=0. stall, forward and out_mxrb are all 0.
//  Match function: match(s) = s.vld & s.wr & (s.rd==id_rb_addr) & (id_rb_addr!=0) & id_valid & id_use_rb.
//  Stall: stall = match(EX) & EX.ld & !hold. Stall is combinational.
//  Advance, on clk edge with hold=0:
//   - WB<=MEM and MEM<=EX.
//   - EX<=ID fields {id_valid&!stall, id_wr_en, id_rd_addr, id_is_load}.
//  Select priority, youngest producer first, registered on the same edge:
//   - match(EX) & !EX.ld -> fwd_sel=MEM. The producer sits in MEM next cycle.
//   - else match(MEM) -> fwd_sel=WB.
//   - else match(WB) -> fwd_sel=RET, and ret_data<=wb_result. The producer retires at this edge.
//   - else, or if stall -> fwd_sel=NONE.
//  Outputs, combinational from fwd_sel:
//   - NONE: forward=0, out_mxrb=0.
//   - MEM: forward=1, out_mxrb=mem_result.
//   - WB: forward=1, out_mxrb=wb_result.
//   - RET: forward=1, out_mxrb=ret_data.
//  Latency: a match seen in ID cycle N drives forward during EX cycle N+1.
//  Load-use: the ID instruction repeats in the next cycle. By then the load has moved to MEM.
//   That match resolves to fwd_sel=WB, so stall lasts exactly 1 cycle.
//  hold=1: slots, fwd_sel and ret_data are frozen. stall is forced to 0.
//   Outputs keep tracking mem_result/wb_result, which upstream also holds stable.
//  id_valid=0 or id_use_rb=0: no match. fwd_sel=NONE, and EX receives a bubble if id_valid=0.
//  Multiple slots match the same register: the youngest slot wins.
//  Reset asserted mid-operation: all state clears immediately. No partial forward survives.
// TESTING
//  1. r3 written in I0, I1 reads rb=r3 -> I1 in EX: forward=1, out_mxrb=mem_result (0x0000_00AA).
//  2. Producer 2 ahead (one gap) -> forward=1, out_mxrb=wb_result (0x1234_5678).
//  3. Producer 3 ahead -> forward=1, out_mxrb=captured 0xDEAD_BEEF, even after wb_result changes.
//  4. lw r5, then add rb=r5 -> stall=1 for 1 cycle, EX bubble, then forward=1 from wb_result.
//  5. Writes to r0, id_use_rb=0, or id_valid=0 -> forward=0, out_mxrb=0.
//  6. Same register written in EX and MEM slots -> MEM source selected.
//  7. hold=1 for 3 cycles mid-forward -> outputs stable. reset_n low mid-stall -> all outputs 0 at once.

Source files
------------

// File: rtl/fwd_unit_b.sv
// Operand-B forwarding and load-use hazard unit.
// Tracks EX/MEM/WB destinations and registers the mx_b forward select.
module fwd_unit_b #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rb_addr,
  input  logic              id_use_rb,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_is_load,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  output logic              stall,
  output logic              forward,
  output logic [DATA_W-1:0] out_mxrb
);

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } slot_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MEM,
    SEL_WB,
    SEL_RET
  } sel_e;

  slot_t             ex_q;
  slot_t             mem_q;
  slot_t             wb_q;
  slot_t             ex_d;
  sel_e              sel_q;
  sel_e              sel_d;
  logic [DATA_W-1:0] ret_q;
  logic              cap_ret;
  logic              rb_live;
  logic              m_ex;
  logic              m_mem;
  logic              m_wb;

  // r0 never forwards; only real readers of rb can match
  assign rb_live = id_valid & id_use_rb
                 & (id_rb_addr != '0);
  assign m_ex  = rb_live & ex_q.vld & ex_q.wr
               & (ex_q.rd == id_rb_addr);
  assign m_mem = rb_live & mem_q.vld & mem_q.wr
               & (mem_q.rd == id_rb_addr);
  assign m_wb  = rb_live & wb_q.vld & wb_q.wr
               & (wb_q.rd == id_rb_addr);

  // a load in EX cannot feed the next EX; freeze wins
  assign stall = m_ex & ex_q.ld & ~hold;

  // next EX slot and youngest-first forward select
  always_comb begin
    sel_d   = SEL_NONE;
    cap_ret = 1'b0;
    ex_d.vld = id_valid & ~stall;
    ex_d.wr  = id_wr_en;
    ex_d.rd  = id_rd_addr;
    ex_d.ld  = id_is_load;
    if (stall) begin
      sel_d = SEL_NONE;
    end else if (m_ex & ~ex_q.ld) begin
      sel_d = SEL_MEM;
    end else if (m_mem) begin
      sel_d = SEL_WB;
    end else if (m_wb) begin
      sel_d   = SEL_RET;
      cap_ret = 1'b1;
    end
  end

  // slot pipeline, select and retired-data capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      sel_q <= SEL_NONE;
      ret_q <= '0;
    end else if (!hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      sel_q <= sel_d;
      if (cap_ret) ret_q <= wb_result;
    end
  end

  // operand mux feeding mx_b
  always_comb begin
    forward  = 1'b0;
    out_mxrb = '0;
    unique case (sel_q)
      SEL_MEM: begin
        forward  = 1'b1;
        out_mxrb = mem_result;
      end
      SEL_WB: begin
        forward  = 1'b1;
        out_mxrb = wb_result;
      end
      SEL_RET: begin
        forward  = 1'b1;
        out_mxrb = ret_q;
      end
      default: begin
        forward  = 1'b0;
        out_mxrb = '0;
      end
    endcase
  end

endmodule
